// File: rtl/uctl_pkg.sv
// ---------------------------------------------------------------------------
// uctl_pkg : shared PID codes, error codes and FSM encoding for the USB token rx
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package uctl_pkg;

  localparam int MAX_GAP_DEFAULT = 16;

  // Token PIDs (low nibble of the PID byte)
  localparam logic [3:0] PID_OUT   = 4'b0001;
  localparam logic [3:0] PID_IN    = 4'b1001;
  localparam logic [3:0] PID_SOF   = 4'b0101;
  localparam logic [3:0] PID_SETUP = 4'b1101;
  localparam logic [3:0] PID_PING  = 4'b0100;

  // Data and handshake PIDs
  localparam logic [3:0] PID_DATA0 = 4'b0011;
  localparam logic [3:0] PID_DATA1 = 4'b1011;
  localparam logic [3:0] PID_DATA2 = 4'b0111;
  localparam logic [3:0] PID_MDATA = 4'b1111;
  localparam logic [3:0] PID_ACK   = 4'b0010;
  localparam logic [3:0] PID_NAK   = 4'b1010;
  localparam logic [3:0] PID_STALL = 4'b1110;
  localparam logic [3:0] PID_NYET  = 4'b0110;

  localparam logic [1:0] ERR_CRC = 2'd0;
  localparam logic [1:0] ERR_PID = 2'd1;
  localparam logic [1:0] ERR_LEN = 2'd2;
  localparam logic [1:0] ERR_RX  = 2'd3;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE     = 3'd0;
  localparam state_t S_PID      = 3'd1;
  localparam state_t S_BYTE1    = 3'd2;
  localparam state_t S_BYTE2    = 3'd3;
  localparam state_t S_WAIT_EOP = 3'd4;
  localparam state_t S_CHECK    = 3'd5;
  localparam state_t S_DRAIN    = 3'd6;

  function automatic logic pid_is_token(input logic [3:0] pid);
    return (pid == PID_OUT) || (pid == PID_IN) || (pid == PID_SOF) ||
           (pid == PID_SETUP) || (pid == PID_PING);
  endfunction

endpackage

`default_nettype wire

// File: rtl/uctl_pid_decode.sv
// ---------------------------------------------------------------------------
// uctl_pid_decode : combinational PID byte check and token classification
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module uctl_pid_decode
  import uctl_pkg::*;
(
  input  logic [7:0] pid_byte,
  output logic       pid_ok,
  output logic       is_token
);

  assign pid_ok   = (pid_byte[7:4] == ~pid_byte[3:0]);
  assign is_token = pid_ok && pid_is_token(pid_byte[3:0]);

endmodule

`default_nettype wire

// File: rtl/uctl_token_rx.sv
// ---------------------------------------------------------------------------
// uctl_token_rx : USB token packet receiver/parser feeding an external CRC5 checker
// Optional: UCTL_TOKEN_ADDR_FILTER_EN adds dev_addr and drops tokens for other devices
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module uctl_token_rx
  import uctl_pkg::*;
#(
  parameter int MAX_GAP = MAX_GAP_DEFAULT
)
(
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_active,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  input  logic        rx_error,
`ifdef UCTL_TOKEN_ADDR_FILTER_EN
  input  logic [6:0]  dev_addr,
`endif
  output logic [10:0] crc_rx_data,
  output logic [4:0]  crc_out,
  output logic        crc_enbl,
  input  logic        crc5_error,
  output logic        tok_valid,
  output logic [3:0]  tok_pid,
  output logic [6:0]  tok_addr,
  output logic [3:0]  tok_endp,
  output logic [10:0] tok_frame,
  output logic        tok_err,
  output logic [1:0]  tok_err_code
);

  localparam int GW = $clog2(MAX_GAP + 1);

  state_t        state, state_nx;
  logic [3:0]    pid_q;
  logic [7:0]    byte1_q, byte2_q;
  logic [GW-1:0] gap_cnt;
  logic          wait_low;

  logic          pid_ok, is_token;
  logic          in_pkt, timeout, addr_ok;
  logic          ld_pid, ld_b1, ld_b2;
  logic          valid_nx, err_nx;
  logic [1:0]    err_code_nx;

  uctl_pid_decode u_pid_decode (
    .pid_byte (rx_data),
    .pid_ok   (pid_ok),
    .is_token (is_token)
  );

  assign in_pkt  = (state == S_PID) || (state == S_BYTE1) ||
                   (state == S_BYTE2) || (state == S_WAIT_EOP);
  assign timeout = in_pkt && rx_active && (gap_cnt == GW'(MAX_GAP));

`ifdef UCTL_TOKEN_ADDR_FILTER_EN
  assign addr_ok = (pid_q == PID_SOF) || (byte1_q[6:0] == dev_addr);
`else
  assign addr_ok = 1'b1;
`endif

  assign crc_rx_data = {byte2_q[2:0], byte1_q};
  assign crc_out     = byte2_q[7:3];
  assign crc_enbl    = (state == S_CHECK);

  always_comb begin
    state_nx    = state;
    ld_pid      = 1'b0;
    ld_b1       = 1'b0;
    ld_b2       = 1'b0;
    valid_nx    = 1'b0;
    err_nx      = 1'b0;
    err_code_nx = ERR_CRC;
    case (state)
      S_IDLE: begin
        if (rx_active && !wait_low) state_nx = S_PID;
      end
      S_PID, S_BYTE1, S_BYTE2, S_WAIT_EOP: begin
        // EOP outranks everything; a byte arriving with rx_active low is dropped
        if (!rx_active) begin
          if (state == S_WAIT_EOP) begin
            state_nx = S_CHECK;
          end else begin
            state_nx = S_IDLE;
            if (state != S_PID) begin
              err_nx      = 1'b1;
              err_code_nx = ERR_LEN;
            end
          end
        end else if (rx_error || timeout) begin
          state_nx    = S_DRAIN;
          err_nx      = 1'b1;
          err_code_nx = ERR_RX;
        end else if (rx_valid) begin
          case (state)
            S_PID: begin
              if (!pid_ok) begin
                state_nx    = S_DRAIN;
                err_nx      = 1'b1;
                err_code_nx = ERR_PID;
              end else if (is_token) begin
                ld_pid   = 1'b1;
                state_nx = S_BYTE1;
              end else begin
                state_nx = S_DRAIN;
              end
            end
            S_BYTE1: begin
              ld_b1    = 1'b1;
              state_nx = S_BYTE2;
            end
            S_BYTE2: begin
              ld_b2    = 1'b1;
              state_nx = S_WAIT_EOP;
            end
            default: begin
              state_nx    = S_DRAIN;
              err_nx      = 1'b1;
              err_code_nx = ERR_LEN;
            end
          endcase
        end
      end
      S_CHECK: begin
        state_nx = S_IDLE;
        if (crc5_error) begin
          err_nx      = 1'b1;
          err_code_nx = ERR_CRC;
        end else begin
          valid_nx = addr_ok;
        end
      end
      S_DRAIN: begin
        if (!rx_active) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      pid_q        <= '0;
      byte1_q      <= '0;
      byte2_q      <= '0;
      gap_cnt      <= '0;
      // a packet already in flight at reset must end before a new one is accepted
      wait_low     <= 1'b1;
      tok_valid    <= 1'b0;
      tok_err      <= 1'b0;
      tok_err_code <= '0;
      tok_pid      <= '0;
      tok_addr     <= '0;
      tok_endp     <= '0;
      tok_frame    <= '0;
    end else begin
      state <= state_nx;
      if (!rx_active) wait_low <= 1'b0;
      if (!in_pkt || rx_valid)        gap_cnt <= '0;
      else if (gap_cnt != GW'(MAX_GAP)) gap_cnt <= gap_cnt + 1'b1;
      if (ld_pid) pid_q   <= rx_data[3:0];
      if (ld_b1)  byte1_q <= rx_data;
      if (ld_b2)  byte2_q <= rx_data;
      tok_valid <= valid_nx;
      tok_err   <= err_nx;
      if (err_nx) tok_err_code <= err_code_nx;
      if (valid_nx) begin
        tok_pid   <= pid_q;
        tok_addr  <= byte1_q[6:0];
        tok_endp  <= {byte2_q[2:0], byte1_q[7]};
        tok_frame <= {byte2_q[2:0], byte1_q};
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uctl_token_rx.sv
// ---------------------------------------------------------------------------
// tb_uctl_token_rx : directed, table-driven bench for uctl_token_rx
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_uctl_token_rx;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_active, rx_valid, rx_error;
  logic [7:0]  rx_data;
  logic [10:0] crc_rx_data;
  logic [4:0]  crc_out;
  logic        crc_enbl, crc5_error;
  logic        tok_valid, tok_err;
  logic [3:0]  tok_pid, tok_endp;
  logic [6:0]  tok_addr;
  logic [10:0] tok_frame;
  logic [1:0]  tok_err_code;
`ifdef UCTL_TOKEN_ADDR_FILTER_EN
  logic [6:0]  dev_addr;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  uctl_token_rx dut (
    .clk          (clk),
    .rst          (rst),
    .rx_active    (rx_active),
    .rx_valid     (rx_valid),
    .rx_data      (rx_data),
    .rx_error     (rx_error),
`ifdef UCTL_TOKEN_ADDR_FILTER_EN
    .dev_addr     (dev_addr),
`endif
    .crc_rx_data  (crc_rx_data),
    .crc_out      (crc_out),
    .crc_enbl     (crc_enbl),
    .crc5_error   (crc5_error),
    .tok_valid    (tok_valid),
    .tok_pid      (tok_pid),
    .tok_addr     (tok_addr),
    .tok_endp     (tok_endp),
    .tok_frame    (tok_frame),
    .tok_err      (tok_err),
    .tok_err_code (tok_err_code)
  );

  // USB CRC5 (x^5+x^2+1, init all ones, inverted), returned in crc_out bit order
  function automatic logic [4:0] crc5_field(input logic [10:0] d);
    logic [4:0] c;
    logic [4:0] r;
    logic       fb;
    c = 5'h1f;
    for (int i = 0; i < 11; i++) begin
      fb = d[i] ^ c[4];
      c  = {c[3:0], 1'b0};
      if (fb) c = c ^ 5'b00101;
    end
    c = ~c;
    for (int i = 0; i < 5; i++) r[i] = c[4-i];
    return r;
  endfunction

  function automatic logic [15:0] mk_tok(input logic [6:0] a, input logic [3:0] e);
    logic [10:0] d;
    d = {e, a};
    return {crc5_field(d), d[10:8], d[7:0]};
  endfunction

  // Peer CRC5 checker model
  always_comb crc5_error = crc_enbl && (crc_out != crc5_field(crc_rx_data));

  // Pulse monitor
  int         n_v = 0, n_e = 0, n_both = 0;
  logic [1:0] m_code;
  logic [3:0] m_pid, m_endp;
  logic [6:0] m_addr;
  logic [10:0] m_frame;
  always @(negedge clk) begin
    if (tok_valid) begin
      n_v++;
      m_pid = tok_pid; m_addr = tok_addr; m_endp = tok_endp; m_frame = tok_frame;
    end
    if (tok_err) begin
      n_e++;
      m_code = tok_err_code;
    end
    if (tok_valid && tok_err) n_both++;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic send_pkt(input logic [3:0][7:0] b, input int n);
    @(negedge clk) rx_active = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk) begin rx_valid = 1'b1; rx_data = b[i]; end
      @(negedge clk) rx_valid = 1'b0;
    end
    @(negedge clk) rx_active = 1'b0;
  endtask

  typedef struct {
    string           name;
    logic [3:0][7:0] b;
    int              n;
    int              ev;
    int              ee;
    logic [1:0]      code;
    logic [3:0]      pid;
    logic [6:0]      addr;
    logic [3:0]      endp;
    logic [10:0]     frame;
  } vec_t;

  function automatic vec_t mkv(input string nm, input logic [7:0] pidb, input logic [6:0] a,
                               input logic [3:0] e, input int n, input int ev, input int ee,
                               input logic [1:0] code);
    vec_t        v;
    logic [15:0] t;
    t = mk_tok(a, e);
    v.name = nm; v.b[0] = pidb; v.b[1] = t[7:0]; v.b[2] = t[15:8]; v.b[3] = 8'h55;
    v.n = n; v.ev = ev; v.ee = ee; v.code = code;
    v.pid = pidb[3:0]; v.addr = a; v.endp = e; v.frame = {e, a};
    return v;
  endfunction

  vec_t vecs [12];

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          v0, e0;
    logic [15:0] t;
    logic [3:0][7:0] pk;

    rst = 1'b1; rx_active = 1'b0; rx_valid = 1'b0; rx_error = 1'b0; rx_data = 8'h00;
`ifdef UCTL_TOKEN_ADDR_FILTER_EN
    dev_addr = 7'h3A;
`endif
    repeat (3) @(negedge clk);
    chk("rst_tok", {13'd0, tok_valid, tok_err, tok_err_code, tok_pid, tok_addr, tok_endp}, 0);
    chk("rst_crc", {15'd0, tok_frame, crc_enbl, crc_out}, 0);
    chk("rst_crcdata", {21'd0, crc_rx_data}, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Latency: EOP at edge N -> crc_enbl in N+1 -> tok_valid in N+2
    t = mk_tok(7'h3A, 4'hA);
    send_pkt({8'h55, t[15:8], t[7:0], 8'h69}, 3);
    @(negedge clk);
    chk("lat_crc_enbl", {31'd0, crc_enbl}, 1);
    chk("lat_no_early_valid", {31'd0, tok_valid}, 0);
    chk("lat_crc_rx_data", {21'd0, crc_rx_data}, {21'd0, 4'hA, 7'h3A});
    chk("lat_crc_out", {27'd0, crc_out}, {27'd0, t[15:11]});
    @(negedge clk);
    chk("lat_tok_valid", {31'd0, tok_valid}, 1);
    chk("lat_crc_enbl_off", {31'd0, crc_enbl}, 0);
    chk("lat_fields", {17'd0, tok_pid, tok_addr, tok_endp}, {17'd0, 4'b1001, 7'h3A, 4'hA});
    @(negedge clk);
    chk("lat_pulse_width", {31'd0, tok_valid}, 0);
    repeat (2) @(negedge clk);

    vecs[0]  = mkv("setup0",       8'h2D, 7'h00, 4'h0, 3, 1, 0, 2'd0);
    vecs[1]  = mkv("setup_badcrc", 8'h2D, 7'h00, 4'h0, 3, 0, 1, 2'd0);
    vecs[1].b[2] = 8'h11;
    vecs[2]  = mkv("pid_check",    8'h2C, 7'h12, 4'h3, 3, 0, 1, 2'd1);
    vecs[3]  = mkv("in_tok",       8'h69, 7'h3A, 4'hA, 3, 1, 0, 2'd0);
    vecs[4]  = mkv("short2",       8'hE1, 7'h05, 4'h1, 2, 0, 1, 2'd2);
    vecs[5]  = mkv("long4",        8'hE1, 7'h05, 4'h1, 4, 0, 1, 2'd2);
    vecs[6]  = mkv("data0",        8'hC3, 7'h05, 4'h1, 4, 0, 0, 2'd0);
    vecs[7]  = mkv("sof",          8'hA5, 7'h23, 4'hB, 3, 1, 0, 2'd0);
    vecs[8]  = mkv("ping",         8'hB4, 7'h7F, 4'hF, 3, 1, 0, 2'd0);
    vecs[9]  = mkv("ack",          8'hD2, 7'h00, 4'h0, 1, 0, 0, 2'd0);
    vecs[10] = mkv("pid_only",     8'hE1, 7'h00, 4'h0, 1, 0, 1, 2'd2);
    vecs[11] = mkv("empty",        8'hE1, 7'h00, 4'h0, 0, 0, 0, 2'd0);

`ifdef UCTL_TOKEN_ADDR_FILTER_EN
    dev_addr = 7'h05;
    for (int i = 0; i < 12; i++)
      if (vecs[i].ev != 0 && vecs[i].pid != 4'b0101 && vecs[i].addr != dev_addr) vecs[i].ev = 0;
`endif

    for (int i = 0; i < 12; i++) begin
      v0 = n_v; e0 = n_e;
      send_pkt(vecs[i].b, vecs[i].n);
      repeat (5) @(negedge clk);
      chk({vecs[i].name, "_valid_cnt"}, n_v - v0, vecs[i].ev);
      chk({vecs[i].name, "_err_cnt"}, n_e - e0, vecs[i].ee);
      if (vecs[i].ee != 0) chk({vecs[i].name, "_code"}, {30'd0, m_code}, {30'd0, vecs[i].code});
      if (vecs[i].ev != 0) begin
        chk({vecs[i].name, "_pid"}, {28'd0, m_pid}, {28'd0, vecs[i].pid});
        if (vecs[i].pid == 4'b0101)
          chk({vecs[i].name, "_frame"}, {21'd0, m_frame}, {21'd0, vecs[i].frame});
        else
          chk({vecs[i].name, "_addr_endp"}, {21'd0, m_addr, m_endp},
              {21'd0, vecs[i].addr, vecs[i].endp});
      end
    end

    // Timeout: stall after byte1 with rx_active held high
    v0 = n_v; e0 = n_e;
    t = mk_tok(7'h05, 4'h2);
    @(negedge clk) rx_active = 1'b1;
    @(negedge clk) begin rx_valid = 1'b1; rx_data = 8'hE1; end
    @(negedge clk) rx_valid = 1'b0;
    @(negedge clk) begin rx_valid = 1'b1; rx_data = t[7:0]; end
    @(negedge clk) rx_valid = 1'b0;
    repeat (10) @(negedge clk);
    chk("tmo_not_early", n_e - e0, 0);
    repeat (20) @(negedge clk);
    chk("tmo_err_cnt", n_e - e0, 1);
    chk("tmo_code", {30'd0, m_code}, 3);
    @(negedge clk) rx_active = 1'b0;
    repeat (4) @(negedge clk);
    chk("tmo_once", n_e - e0, 1);
    chk("tmo_no_valid", n_v - v0, 0);

    // rx_error beats a coincident rx_valid and is reported once
    v0 = n_v; e0 = n_e;
    @(negedge clk) rx_active = 1'b1;
    @(negedge clk) begin rx_valid = 1'b1; rx_data = 8'hE1; end
    @(negedge clk) rx_valid = 1'b0;
    @(negedge clk) begin rx_valid = 1'b1; rx_data = t[7:0]; rx_error = 1'b1; end
    @(negedge clk) begin rx_valid = 1'b0; rx_error = 1'b0; end
    @(negedge clk) rx_error = 1'b1;
    @(negedge clk) rx_error = 1'b0;
    @(negedge clk) rx_active = 1'b0;
    repeat (5) @(negedge clk);
    chk("rxerr_cnt", n_e - e0, 1);
    chk("rxerr_code", {30'd0, m_code}, 3);
    chk("rxerr_no_valid", n_v - v0, 0);

    // Reset in BYTE2: outputs clear, remainder of the packet is ignored
    v0 = n_v; e0 = n_e;
    @(negedge clk) rx_active = 1'b1;
    @(negedge clk) begin rx_valid = 1'b1; rx_data = 8'hE1; end
    @(negedge clk) rx_valid = 1'b0;
    @(negedge clk) begin rx_valid = 1'b1; rx_data = t[7:0]; end
    @(negedge clk) rx_valid = 1'b0;
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    chk("mrst_tok", {13'd0, tok_valid, tok_err, tok_err_code, tok_pid, tok_addr, tok_endp}, 0);
    chk("mrst_crc", {15'd0, tok_frame, crc_enbl, crc_out}, 0);
    chk("mrst_crcdata", {21'd0, crc_rx_data}, 0);
    @(negedge clk) begin rx_valid = 1'b1; rx_data = t[15:8]; end
    @(negedge clk) rx_valid = 1'b0;
    @(negedge clk) rx_active = 1'b0;
    repeat (5) @(negedge clk);
    chk("mrst_no_pulse", (n_v - v0) + (n_e - e0), 0);

    // Back-to-back: second rx_active rise in the cycle after CHECK
    v0 = n_v; e0 = n_e;
`ifdef UCTL_TOKEN_ADDR_FILTER_EN
    dev_addr = 7'h00;
`endif
    t = mk_tok(7'h00, 4'h0);
    send_pkt({8'h55, t[15:8], t[7:0], 8'h2D}, 3);
    @(negedge clk);
    t = mk_tok(7'h00, 4'h1);
    send_pkt({8'h55, t[15:8], t[7:0], 8'hE1}, 3);
    repeat (5) @(negedge clk);
    chk("b2b_valid_cnt", n_v - v0, 2);
    chk("b2b_last", {24'd0, m_pid, m_endp}, {24'd0, 4'b0001, 4'h1});
    chk("b2b_err_cnt", n_e - e0, 0);

`ifdef UCTL_TOKEN_ADDR_FILTER_EN
    dev_addr = 7'h05;
    v0 = n_v;
    t = mk_tok(7'h03, 4'h1);
    send_pkt({8'h55, t[15:8], t[7:0], 8'hE1}, 3);
    repeat (5) @(negedge clk);
    chk("flt_other_addr", n_v - v0, 0);
    t = mk_tok(7'h05, 4'h1);
    send_pkt({8'h55, t[15:8], t[7:0], 8'hE1}, 3);
    repeat (5) @(negedge clk);
    chk("flt_own_addr", n_v - v0, 1);
    chk("flt_own_fields", {21'd0, m_addr, m_endp}, {21'd0, 7'h05, 4'h1});
    t = mk_tok(7'h23, 4'h2);
    send_pkt({8'h55, t[15:8], t[7:0], 8'hA5}, 3);
    repeat (5) @(negedge clk);
    chk("flt_sof", n_v - v0, 2);
    chk("flt_sof_frame", {21'd0, m_frame}, {21'd0, 11'h123});
`endif

    chk("valid_err_exclusive", n_both, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/uctl_token_rx.md
Name: uctl_token_rx

Overview:
USB token-packet receiver and parser. It sits between the byte-level packet decoder (UTMI-style rx byte stream) and the CRC5 checker.
- Validates the PID and collects the two token bytes.
- Presents the 11-bit token field and the 5-bit received CRC to the checker, samples the checker's error flag, and issues one decoded token or error pulse per packet.
- Non-token packets are ignored and left to the data/handshake path.

Parameters:
MAX_GAP, 16, max clocks between rx_valid bytes while rx_active=1 before the packet is aborted (timeout).

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
rx_active  input  1  packet in progress; the falling edge marks EOP
rx_valid  input  1  rx_data holds a valid byte this cycle
rx_data  input  8  received byte, LSB = first bit on the wire
rx_error  input  1  decoder error (bitstuff/PHY) in the current packet
crc_rx_data  output  11  {byte2[2:0], byte1[7:0]} to the CRC5 checker
crc_out  output  5  byte2[7:3], the received CRC5, to the checker
crc_enbl  output  1  checker enable; high only in CHECK
crc5_error  input  1  checker result, combinational, valid in the same cycle as crc_enbl
tok_valid  output  1  one-cycle pulse: good token
tok_pid  output  4  PID[3:0]: OUT=0001, IN=1001, SETUP=1101, SOF=0101, PING=0100
tok_addr  output  7  byte1[6:0]; don't-care for SOF
tok_endp  output  4  {byte2[2:0], byte1[7]}; don't-care for SOF
tok_frame  output  11  crc_rx_data; meaningful for SOF only
tok_err  output  1  one-cycle pulse: a token packet was rejected
tok_err_code  output  2  0=CRC, 1=PID check, 2=length, 3=rx_error/timeout

Behaviour:
- Reset (rst high at a clk edge):
  - All outputs 0, state IDLE, byte registers 0, gap counter 0.
  - Takes effect mid-packet with no output pulse. After reset the block waits in IDLE for a fresh rx_active rise; it does not resynchronise into a packet already in flight.
- FSM states: IDLE, PID, BYTE1, BYTE2, WAIT_EOP, CHECK, DRAIN.
- IDLE -> PID when rx_active=1.
- PID, on rx_valid:
  - rx_data[7:4] != ~rx_data[3:0]: DRAIN, pulse err code 1.
  - Valid token PID: latch it, go to BYTE1.
  - Any other valid PID (DATA/handshake/special): DRAIN silently.
- BYTE1 -> BYTE2 on rx_valid (latch byte1). BYTE2 -> WAIT_EOP on rx_valid (latch byte2).
- WAIT_EOP:
  - A further rx_valid (4th byte): DRAIN, err code 2.
  - rx_active=0: CHECK.
- rx_active falling in PID, BYTE1 or BYTE2 (short packet): IDLE, err code 2 if the PID was already a valid token, otherwise silent.
- CHECK (exactly 1 cycle):
  - crc_enbl=1; crc_rx_data and crc_out are stable from byte latch until CHECK exits.
  - Sample crc5_error and go to IDLE.
  - Next cycle: tok_valid=1 with tok_* fields, or tok_err=1 with code 0.
- Latency: EOP seen low at edge N -> CHECK in cycle N+1 -> tok_valid/tok_err high in cycle N+2 for exactly 1 cycle.
- DRAIN -> IDLE when rx_active=0; no further pulses from DRAIN.
- rx_error=1 in PID/BYTE1/BYTE2/WAIT_EOP: DRAIN, err code 3, reported once per packet.
- Timeout:
  - The gap counter resets on each rx_valid and saturates at MAX_GAP.
  - Reaching MAX_GAP in PID..WAIT_EOP with rx_active=1: DRAIN, err code 3.
- Simultaneous events in one cycle:
  - rx_error has priority over rx_valid.
  - rx_valid with rx_active=0 is ignored.
- tok_valid and tok_err are never high together.
- tok_pid/addr/endp/frame hold their last values between pulses.
- Back-to-back packets: rx_active re-rising in the cycle after CHECK is accepted, since IDLE samples it.

Optional Feature:
UCTL_TOKEN_ADDR_FILTER_EN
- Defined:
  - Adds input dev_addr[6:0].
  - A CRC-good, non-SOF token with tok_addr != dev_addr produces no pulse at all.
  - SOF is always passed.
- Undefined: the port is absent and every CRC-good token pulses tok_valid.

Decomposition:
- Shared package uctl_pkg:
  - PID constants (OUT/IN/SETUP/SOF/PING and the data/handshake codes).
  - Error-code constants.
  - FSM state typedef.
  - MAX_GAP default.
- One natural sub-module: uctl_pid_decode, combinational. Input: PID byte. Outputs: pid_ok, is_token.
- The CRC5 checker stays a separate instance, wired at the parent.

Test Plan:
- SETUP addr 0 endp 0: bytes 0x2D,0x00,0x10, then EOP, checker model returns 0 -> crc_enbl in N+1; tok_valid in N+2 with pid=1101, addr=0, endp=0.
- Same packet with 3rd byte 0x11 and checker model returning 1 -> tok_err, code 0, no tok_valid.
- PID byte 0x2C -> tok_err code 1; bytes that follow ignored until EOP.
- Token with only 2 bytes before EOP -> code 2. Token with 4 bytes -> code 2 once.
- rx_active held high, no rx_valid for 16 cycles after byte1 -> code 3. rst asserted mid-BYTE2 -> all outputs 0, no pulse.
- DATA0 (0xC3) packet -> no pulses. With UCTL_TOKEN_ADDR_FILTER_EN and dev_addr=5:
  - OUT to addr 3 -> no pulse.
  - OUT to addr 5 -> tok_valid.
  - SOF -> tok_valid, tok_frame correct.
